// File: rtl/jtag_master.sv
// JTAG TAP initiator: TAP reset, IR and DR scans issued from a command port.
// Define JTAG_MASTER_TDO_CHECK_EN to add masked TDO compare (tdo_expect/tdo_mask/mismatch).
//
// state   | meaning
// RST_SEQ | TMS 1,1,1,1,1,0 walk into Run-Test/Idle (automatic after reset, or commanded)
// IDLE    | target parked in Run-Test/Idle, TCK=0, TMS=0, ready for a command
// PRE     | TMS preamble from Idle into Shift-IR / Shift-DR
// SHIFT   | N shift TCKs, TMS high on the last one
// POST    | Exit1 -> Update -> Run-Test/Idle
// FIN     | one-cycle done pulse; a new command may be accepted here
module jtag_master #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9
) (
    input  logic               wb_clk_i,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] tdi_data,
    output logic [MAX_LEN-1:0] tdo_data,
`ifdef JTAG_MASTER_TDO_CHECK_EN
    input  logic [MAX_LEN-1:0] tdo_expect,
    input  logic [MAX_LEN-1:0] tdo_mask,
    output logic               mismatch,
`endif
    output logic               done,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam int DIV_W = $clog2(TCK_DIV + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TCK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        RST_SEQ,
        IDLE,
        PRE,
        SHIFT,
        POST,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic [LEN_W-1:0]   last_step, last_shift;
    logic [LEN_W-1:0]   len_q, len_clamp;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               ir_q, rst_cmd_q;
    logic [MAX_LEN-1:0] din_q, tdo_q;
    logic               ready_q, busy_q, done_q;
    logic               accept, capture, is_scan, scan_go;

    assign accept     = cmd_valid && ready_q;
    assign len_clamp  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign is_scan    = (cmd_type == 2'b01) || (cmd_type == 2'b10);
    assign scan_go    = is_scan && (len_clamp != '0);
    assign last_shift = len_q - LEN_W'(1);

    function automatic logic tms_at(state_t s, logic [LEN_W-1:0] idx, logic ir,
                                    logic [LEN_W-1:0] last_idx);
        case (s)
            RST_SEQ: return idx != LEN_W'(5);
            PRE:     return ir ? (idx < LEN_W'(2)) : (idx == '0);
            SHIFT:   return idx == last_idx;
            POST:    return idx == '0;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            RST_SEQ: last_step = LEN_W'(5);
            PRE:     last_step = ir_q ? LEN_W'(3) : LEN_W'(2);
            SHIFT:   last_step = last_shift;
            default: last_step = LEN_W'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        div_d   = div_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        capture = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept) begin
                    div_d  = DIV_LOAD;
                    step_d = '0;
                    tck_d  = 1'b0;
                    tdi_d  = 1'b0;
                    if (cmd_type == 2'b00) begin
                        state_d = RST_SEQ;
                        tms_d   = 1'b1;
                    end else if (scan_go) begin
                        state_d = PRE;
                        tms_d   = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            default: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (!tck_q) begin
                    tck_d   = 1'b1;
                    div_d   = DIV_LOAD;
                    capture = (state_q == SHIFT);
                end else begin
                    // end of a high phase: step to the next TCK and set up TMS/TDI for it
                    tck_d = 1'b0;
                    div_d = DIV_LOAD;
                    if (step_q != last_step) begin
                        step_d = step_q + LEN_W'(1);
                    end else begin
                        step_d = '0;
                        case (state_q)
                            RST_SEQ: state_d = rst_cmd_q ? FIN : IDLE;
                            PRE:     state_d = SHIFT;
                            SHIFT:   state_d = POST;
                            default: state_d = FIN;
                        endcase
                    end
                    tms_d = tms_at(state_d, step_d, ir_q, last_shift);
                    tdi_d = (state_d == SHIFT) ? din_q[step_d[IDX_W-1:0]] : 1'b0;
                end
            end
        endcase
    end

    // The first low phase after reset is one cycle longer so the boot sequence
    // lines up with the accept-to-first-low-phase latency of a normal command.
    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_SEQ;
            step_q  <= '0;
            div_q   <= DIV_W'(TCK_DIV);
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= (state_d == IDLE) || (state_d == FIN);
            busy_q  <= !((state_d == IDLE) || (state_d == FIN));
            done_q  <= (state_d == FIN);
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            ir_q      <= 1'b0;
            rst_cmd_q <= 1'b0;
            len_q     <= '0;
            din_q     <= '0;
            tdo_q     <= '0;
        end else if (accept) begin
            ir_q      <= (cmd_type == 2'b01);
            rst_cmd_q <= (cmd_type == 2'b00);
            len_q     <= len_clamp;
            din_q     <= tdi_data;
            if (scan_go) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i >= int'(len_clamp)) tdo_q[i] <= 1'b0;
                end
            end
        end else if (capture) begin
            tdo_q[step_q[IDX_W-1:0]] <= TDO;
        end
    end

`ifdef JTAG_MASTER_TDO_CHECK_EN
    logic [MAX_LEN-1:0] exp_q, chk_q;
    logic               mis_q;

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            exp_q <= '0;
            chk_q <= '0;
            mis_q <= 1'b0;
        end else begin
            if (accept) begin
                exp_q <= tdo_expect;
                for (int i = 0; i < MAX_LEN; i++) begin
                    chk_q[i] <= tdo_mask[i] && scan_go && (i < int'(len_clamp));
                end
            end
            if (state_d == FIN) begin
                mis_q <= (state_q == POST) && (|((tdo_q ^ exp_q) & chk_q));
            end
        end
    end

    assign mismatch = mis_q;
`endif

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tdo_data  = tdo_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master against a behavioural 1149.1 TAP (3-bit IR, bypass DR).
`timescale 1ns/1ps
module tb_jtag_master;

    localparam int MAX_LEN = 256;
    localparam logic [255:0] PAT = {8{32'hC3A5_1E69}};

    logic               wb_clk_i = 1'b0;
    logic               resetn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_type;
    logic [8:0]         cmd_len;
    logic [MAX_LEN-1:0] tdi_data;
    logic [MAX_LEN-1:0] tdo_data;
    logic               done, busy, TCK, TMS, TDI;
    logic               tdo_tap = 1'b0;
`ifdef JTAG_MASTER_TDO_CHECK_EN
    logic [MAX_LEN-1:0] tdo_expect;
    logic [MAX_LEN-1:0] tdo_mask;
    logic               mismatch;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    jtag_master #(.TCK_DIV(2), .MAX_LEN(MAX_LEN), .LEN_W(9)) dut (
        .wb_clk_i  (wb_clk_i),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .tdi_data  (tdi_data),
        .tdo_data  (tdo_data),
`ifdef JTAG_MASTER_TDO_CHECK_EN
        .tdo_expect(tdo_expect),
        .tdo_mask  (tdo_mask),
        .mismatch  (mismatch),
`endif
        .done      (done),
        .busy      (busy),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (tdo_tap)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef enum logic [3:0] {
        T_TLR, T_IDLE, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR, T_EX2_DR, T_UPD_DR,
        T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR, T_EX2_IR, T_UPD_IR
    } tap_t;

    tap_t        tap_st    = T_TLR;
    logic [2:0]  ir_sr     = 3'b000;
    logic [2:0]  ir_reg    = 3'b000;
    logic        byp_r     = 1'b0;
    int          tck_rises = 0;
    logic [31:0] tms_log   = '0;

    function automatic tap_t tap_next(tap_t s, logic tms);
        case (s)
            T_TLR:    return tms ? T_TLR    : T_IDLE;
            T_IDLE:   return tms ? T_SEL_DR : T_IDLE;
            T_SEL_DR: return tms ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return tms ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return tms ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return tms ? T_UPD_DR : T_PAU_DR;
            T_PAU_DR: return tms ? T_EX2_DR : T_PAU_DR;
            T_EX2_DR: return tms ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return tms ? T_SEL_DR : T_IDLE;
            T_SEL_IR: return tms ? T_TLR    : T_CAP_IR;
            T_CAP_IR: return tms ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return tms ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return tms ? T_UPD_IR : T_PAU_IR;
            T_PAU_IR: return tms ? T_EX2_IR : T_PAU_IR;
            T_EX2_IR: return tms ? T_UPD_IR : T_SH_IR;
            T_UPD_IR: return tms ? T_SEL_DR : T_IDLE;
            default:  return T_TLR;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap_st)
            T_CAP_DR: byp_r  <= 1'b0;
            T_SH_DR:  byp_r  <= TDI;
            T_CAP_IR: ir_sr  <= 3'b001;
            T_SH_IR:  ir_sr  <= {TDI, ir_sr[2:1]};
            T_UPD_IR: ir_reg <= ir_sr;
            default:  ;
        endcase
        tap_st    <= tap_next(tap_st, TMS);
        tck_rises <= tck_rises + 1;
        tms_log   <= {tms_log[30:0], TMS};
    end

    always @(negedge TCK) begin
        tdo_tap <= (tap_st == T_SH_DR) ? byp_r : ((tap_st == T_SH_IR) ? ir_sr[0] : 1'b0);
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic release_and_check(input string tag);
        int   base;
        int   ready_cyc;
        logic saw_done;
        @(negedge wb_clk_i);
        resetn    = 1'b1;
        base      = tck_rises;
        ready_cyc = -1;
        saw_done  = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (done) saw_done = 1'b1;
            if (cmd_ready) begin
                ready_cyc = c;
                break;
            end
        end
        check_eq({tag, "_ready_cyc"}, 256'(ready_cyc), 256'd25);
        check_eq({tag, "_tck_cnt"}, 256'(tck_rises - base), 256'd6);
        check_eq({tag, "_tms_seq"}, 256'(tms_log[5:0]), 256'(6'b111110));
        check_eq({tag, "_no_done"}, 256'(saw_done), 256'd0);
        check_eq({tag, "_tap_idle"}, 256'(tap_st == T_IDLE), 256'd1);
    endtask

    task automatic run_cmd(input logic [1:0] typ, input int len, input logic [255:0] data,
                           input int hold, output int done_cyc, output int n_tck);
        int base;
        @(negedge wb_clk_i);
        cmd_type  = typ;
        cmd_len   = 9'(len);
        tdi_data  = data;
        cmd_valid = 1'b1;
        base      = tck_rises;
        done_cyc  = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (c >= hold) cmd_valid = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        n_tck     = tck_rises - base;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nt, base, waited;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_len   = '0;
        tdi_data  = '0;
`ifdef JTAG_MASTER_TDO_CHECK_EN
        tdo_expect = '0;
        tdo_mask   = '0;
`endif
        #12;
        check_eq("rst_tck", 256'(TCK), 256'd0);
        check_eq("rst_tms", 256'(TMS), 256'd1);
        check_eq("rst_tdi", 256'(TDI), 256'd0);
        check_eq("rst_ready", 256'(cmd_ready), 256'd0);
        check_eq("rst_busy", 256'(busy), 256'd0);
        check_eq("rst_done", 256'(done), 256'd0);
        check_eq("rst_tdo", tdo_data, 256'd0);
        release_and_check("boot");

        run_cmd(2'b01, 3, 256'b010, 1, dc, nt);
        check_eq("ir_done_cyc", 256'(dc), 256'd37);
        check_eq("ir_ready", 256'(cmd_ready), 256'd1);
        check_eq("ir_busy", 256'(busy), 256'd0);
        check_eq("ir_tms_seq", 256'(tms_log[8:0]), 256'(9'b110000110));
        check_eq("ir_tdo", tdo_data, 256'h1);
        check_eq("ir_target_ir", 256'(ir_reg), 256'(3'b010));

        run_cmd(2'b10, 300, PAT, 1, dc, nt);
        check_eq("clamp_done_cyc", 256'(dc), 256'd1045);
        check_eq("clamp_tck_cnt", 256'(nt), 256'd261);
        check_eq("clamp_tdo", tdo_data, PAT << 1);

        run_cmd(2'b10, 8, 256'hA5, 10, dc, nt);
        check_eq("byp_done_cyc", 256'(dc), 256'd53);
        check_eq("byp_tck_cnt", 256'(nt), 256'd13);
        check_eq("byp_tdo", tdo_data, 256'h4A);
        check_eq("byp_tms_seq", 256'(tms_log[12:0]), 256'(13'b1000000000110));
        base = tck_rises;
        repeat (4) @(negedge wb_clk_i);
        check_eq("byp_no_requeue_busy", 256'(busy), 256'd0);
        check_eq("byp_no_requeue_tck", 256'(tck_rises - base), 256'd0);

        run_cmd(2'b10, 0, 256'hFF, 1, dc, nt);
        check_eq("len0_done_cyc", 256'(dc), 256'd1);
        check_eq("len0_tck_cnt", 256'(nt), 256'd0);
        check_eq("len0_tdo", tdo_data, 256'h4A);

        run_cmd(2'b11, 5, 256'h1F, 1, dc, nt);
        check_eq("nop_done_cyc", 256'(dc), 256'd1);
        check_eq("nop_tck_cnt", 256'(nt), 256'd0);
        check_eq("nop_tdo", tdo_data, 256'h4A);

        run_cmd(2'b00, 0, 256'h0, 1, dc, nt);
        check_eq("taprst_done_cyc", 256'(dc), 256'd25);
        check_eq("taprst_tms_seq", 256'(tms_log[5:0]), 256'(6'b111110));
        check_eq("taprst_tap_idle", 256'(tap_st == T_IDLE), 256'd1);

        @(negedge wb_clk_i);
        cmd_type  = 2'b10;
        cmd_len   = 9'd253;
        tdi_data  = PAT;
        cmd_valid = 1'b1;
        base      = tck_rises;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        waited    = 0;
        while ((tck_rises - base) < 104 && waited < 2000) begin
            @(negedge wb_clk_i);
            waited++;
        end
        check_eq("mid_reached_bit100", 256'(tck_rises - base), 256'd104);
        check_eq("mid_tck_high", 256'(TCK), 256'd1);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_tck", 256'(TCK), 256'd0);
        check_eq("mid_rst_tms", 256'(TMS), 256'd1);
        check_eq("mid_rst_busy", 256'(busy), 256'd0);
        check_eq("mid_rst_ready", 256'(cmd_ready), 256'd0);
        check_eq("mid_rst_tdo", tdo_data, 256'd0);
        repeat (2) @(negedge wb_clk_i);
        release_and_check("mid");

`ifdef JTAG_MASTER_TDO_CHECK_EN
        check_eq("chk_rst_mismatch", 256'(mismatch), 256'd0);
        tdo_expect = 256'h4A;
        tdo_mask   = 256'hFF;
        run_cmd(2'b10, 8, 256'hA5, 1, dc, nt);
        check_eq("chk_match", 256'(mismatch), 256'd0);
        tdo_expect = 256'h4B;
        run_cmd(2'b10, 8, 256'hA5, 1, dc, nt);
        check_eq("chk_miss", 256'(mismatch), 256'd1);
        tdo_mask = 256'hFE;
        run_cmd(2'b10, 8, 256'hA5, 1, dc, nt);
        check_eq("chk_masked", 256'(mismatch), 256'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
